timer_controller: RTL and testbench
===================================

# timer_controller

Programmable timer controller that sequences an internal runtime-configurable prescaler and countdown counter from the system clock, replacing fixed-ratio divider chains where software needs adjustable periods. A small register interface configures prescale ratio, reload value and mode, and starts or stops the timer. Expiry is signalled by a one-cycle `tick_out` pulse and a sticky `irq` with acknowledge handshake. The block sits beside the clock generators and feeds peripherals and the interrupt logic.

## Interface
- `WIDTH`, 16: width of the prescale, reload and count registers and of `wr_data` / `rd_data`.
- `clk`  in  1  system clock (50 MHz nominal).
- `rst`  in  1  synchronous, active-high reset.
- `en`  in  1  global enable; low freezes the prescaler and countdown, while register writes are still accepted.
- `wr`  in  1  register write strobe, one cycle per write.
- `addr`  in  2  register select: 0 CTRL, 1 PRESCALE, 2 RELOAD, 3 COUNT (read-only).
- `wr_data`  in  WIDTH  write data.
- `rd_data`  out  WIDTH  registered read of the register at `addr`.
- `irq`  out  1  sticky expiry flag.
- `irq_ack`  in  1  clears `irq`.
- `tick_out`  out  1  one-cycle pulse per expiry.
- `running`  out  1  high in the RUNNING state.

## Operation
- CTRL write bits: bit0 START, bit1 PERIODIC (stored), bit2 STOP. START and STOP are self-clearing. CTRL reads back `{running, periodic}` in bits [1:0].
- States: IDLE and RUNNING.
- START from either state:
  - load `count` from RELOAD and clear the prescaler;
  - go to RUNNING. START while RUNNING is a restart.
- STOP: go to IDLE; `count` holds its value and `irq` is untouched. If START and STOP are written together, STOP wins.
- Prescaler counts 0 to PRESCALE. `ptick` = RUNNING & `en` & (pcnt >= PRESCALE). On `ptick` the prescaler returns to 0; otherwise it increments when RUNNING & `en`.
  - Using >= means a PRESCALE write below the current pcnt wraps on the next enabled cycle.
  - PRESCALE=0 gives a `ptick` on every enabled cycle.
- On `ptick`:
  - if `count` != 0, decrement it;
  - if `count` == 0, expire: set `irq`, pulse `tick_out` on the next cycle, then:
    - PERIODIC=1: reload `count` from RELOAD and stay RUNNING;
    - PERIODIC=0: go to IDLE.
- RELOAD=0 expires on the first `ptick`.
- RELOAD and PRESCALE writes while RUNNING: RELOAD takes effect at the next START or periodic reload; PRESCALE takes effect immediately.
- `irq_ack` clears `irq`. If an expiry and `irq_ack` occur in the same cycle, `irq` stays 1 (set wins).
- Writes to COUNT are ignored.
- Reset values: state IDLE; `count`, PRESCALE, RELOAD, PERIODIC, pcnt, `irq`, `tick_out`, `rd_data` all 0; `running` 0.
- `rst` mid-run returns the block to IDLE with no `tick_out` pulse.

## Timing
- Register write at edge t is visible internally at t+1. `rd_data` reflects `addr` sampled at t, valid at t+1.
- START written at t: `running`=1 from t+1.
- Expiry `ptick` occurs at cycle t+(R+1)(P+1), where R = RELOAD and P = PRESCALE, with `en` held high.
- `tick_out` is high at t+(R+1)(P+1)+1 for exactly one cycle. `irq` rises the same cycle.
- One-shot: `running` falls the same cycle `tick_out` rises.
- Periodic: spacing between `tick_out` pulses is exactly (R+1)(P+1) cycles.
- Each cycle with `en` low delays all of the above by one cycle.

## Structure
- Shared package holds:
  - address localparams: ADDR_CTRL, ADDR_PRESCALE, ADDR_RELOAD, ADDR_COUNT;
  - CTRL bit indices: CTRL_START, CTRL_PERIODIC, CTRL_STOP;
  - the state encoding (IDLE, RUNNING).
- One sub-module, `prescaler`: clk, rst, clear, run, limit → `ptick`, with the >= wrap rule.
- Register file, FSM and countdown live in `timer_controller`.

## Test plan
- Reset, then read all four addresses → every read returns 0; `irq`=0, `tick_out`=0, `running`=0.
- PRESCALE=0, RELOAD=0, one-shot START at t → `tick_out` at t+2, `running` low from t+2, `irq`=1 until `irq_ack`.
- PRESCALE=4, RELOAD=9, periodic START → first `tick_out` 50 cycles after START, then every 50 cycles, checked for 5 periods. COUNT reads track the decrement.
- `en` held low for 7 cycles mid-run with PRESCALE=4, RELOAD=9 → that expiry is delayed by exactly 7 cycles, following expiries keep 50-cycle spacing.
- Coincident events:
  - START and STOP in one write → stays IDLE;
  - `irq_ack` in the cycle `irq` would be set → `irq`=1;
  - `rst` one cycle before expiry → no `tick_out`, all outputs 0.
- Restart while RUNNING (START at count=3) → count reloads to RELOAD, expiry is timed from the new START.

Source files
------------

// File: rtl/timer_controller_pkg.sv
// Shared definitions for the programmable timer controller: register map,
// CTRL bit positions and the controller state encoding.
package timer_controller_pkg;

  // Register map
  localparam logic [1:0] ADDR_CTRL     = 2'd0;
  localparam logic [1:0] ADDR_PRESCALE = 2'd1;
  localparam logic [1:0] ADDR_RELOAD   = 2'd2;
  localparam logic [1:0] ADDR_COUNT    = 2'd3;

  // CTRL write bit positions (START and STOP are self-clearing strobes)
  localparam int CTRL_START    = 0;
  localparam int CTRL_PERIODIC = 1;
  localparam int CTRL_STOP     = 2;

  // Controller state encoding
  localparam logic [0:0] ST_IDLE    = 1'b0;
  localparam logic [0:0] ST_RUNNING = 1'b1;

endpackage

// File: rtl/timer_controller_prescaler.sv
// Runtime-configurable prescaler. Counts 0..limit while run is high and
// emits ptick on the terminal count. The >= compare makes a limit lowered
// below the current count wrap on the next enabled cycle instead of
// running all the way around the counter.
module prescaler
  import timer_controller_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             run,
  input  logic [WIDTH-1:0] limit,
  output logic             ptick
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] pcnt_q;
  logic [WIDTH-1:0] pcnt_d;

  // Terminal-count detect and next prescale count
  always_comb begin
    ptick  = run && (pcnt_q >= limit);
    pcnt_d = pcnt_q;
    if (clear) begin
      pcnt_d = '0;
    end else if (ptick) begin
      pcnt_d = '0;
    end else if (run) begin
      pcnt_d = pcnt_q + ONE;
    end else begin
      pcnt_d = pcnt_q;
    end
  end

  // Prescale count register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      pcnt_q <= '0;
    end else begin
      pcnt_q <= pcnt_d;
    end
  end

endmodule

// File: rtl/timer_controller.sv
// Programmable timer controller: register file, IDLE/RUNNING sequencer and
// countdown counter driven by the prescaler tick. Expiry produces a
// one-cycle tick_out pulse and a sticky irq cleared by irq_ack.
module timer_controller
  import timer_controller_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             wr,
  input  logic [1:0]       addr,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic             irq,
  input  logic             irq_ack,
  output logic             tick_out,
  output logic             running
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [0:0]       state_q,    state_d;
  logic [WIDTH-1:0] count_q,    count_d;
  logic [WIDTH-1:0] prescale_q, prescale_d;
  logic [WIDTH-1:0] reload_q,   reload_d;
  logic             periodic_q, periodic_d;
  logic             irq_q,      irq_d;
  logic             tick_q,     tick_d;
  logic [WIDTH-1:0] rd_data_q,  rd_data_d;

  logic running_s;
  logic ctrl_wr_s;
  logic start_s;
  logic stop_s;
  logic run_s;
  logic clear_s;
  logic ptick_s;
  logic expire_s;

  // Decode control strobes; STOP beats START, and a (re)start beats expiry
  always_comb begin
    running_s = (state_q == ST_RUNNING);
    ctrl_wr_s = wr && (addr == ADDR_CTRL);
    start_s   = ctrl_wr_s && wr_data[CTRL_START];
    stop_s    = ctrl_wr_s && wr_data[CTRL_STOP];
    run_s     = running_s && en;
    clear_s   = start_s && !stop_s;
    expire_s  = ptick_s && (count_q == '0) && !stop_s && !start_s;
  end

  prescaler #(
    .WIDTH (WIDTH)
  ) u_prescaler (
    .clk   (clk),
    .rst   (rst),
    .clear (clear_s),
    .run   (run_s),
    .limit (prescale_q),
    .ptick (ptick_s)
  );

  // Register writes, state sequencing, countdown and expiry flags
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    prescale_d = prescale_q;
    reload_d   = reload_q;
    periodic_d = periodic_q;

    if (wr) begin
      case (addr)
        ADDR_CTRL:     periodic_d = wr_data[CTRL_PERIODIC];
        ADDR_PRESCALE: prescale_d = wr_data;
        ADDR_RELOAD:   reload_d   = wr_data;
        default:       periodic_d = periodic_q;  // COUNT is read-only
      endcase
    end else begin
      periodic_d = periodic_q;
    end

    if (stop_s) begin
      state_d = ST_IDLE;
    end else if (start_s) begin
      state_d = ST_RUNNING;
      count_d = reload_q;
    end else if (ptick_s) begin
      if (count_q != '0) begin
        count_d = count_q - ONE;
      end else if (periodic_q) begin
        count_d = reload_q;
      end else begin
        state_d = ST_IDLE;
      end
    end else begin
      state_d = state_q;
    end

    // Set wins over acknowledge
    if (expire_s) begin
      irq_d = 1'b1;
    end else if (irq_ack) begin
      irq_d = 1'b0;
    end else begin
      irq_d = irq_q;
    end

    tick_d = expire_s;
  end

  // Registered read mux over the register map
  always_comb begin
    rd_data_d = '0;
    case (addr)
      ADDR_CTRL:     rd_data_d = {{(WIDTH-2){1'b0}}, running_s, periodic_q};
      ADDR_PRESCALE: rd_data_d = prescale_q;
      ADDR_RELOAD:   rd_data_d = reload_q;
      ADDR_COUNT:    rd_data_d = count_q;
      default:       rd_data_d = '0;
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      count_q    <= '0;
      prescale_q <= '0;
      reload_q   <= '0;
      periodic_q <= 1'b0;
      irq_q      <= 1'b0;
      tick_q     <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      prescale_q <= prescale_d;
      reload_q   <= reload_d;
      periodic_q <= periodic_d;
      irq_q      <= irq_d;
      tick_q     <= tick_d;
      rd_data_q  <= rd_data_d;
    end
  end

  assign rd_data  = rd_data_q;
  assign irq      = irq_q;
  assign tick_out = tick_q;
  assign running  = running_s;

endmodule

// File: tb/tb_timer_controller.sv
// Self-checking bench for timer_controller. Expected timing is derived from
// the count of enabled cycles since START: expiry every (R+1)(P+1) enabled
// cycles, COUNT = R - (completed prescale periods mod (R+1)).
module tb_timer_controller;

  localparam int WIDTH = 16;

  logic             clk;
  logic             rst;
  logic             en;
  logic             wr;
  logic [1:0]       addr;
  logic [WIDTH-1:0] wr_data;
  logic [WIDTH-1:0] rd_data;
  logic             irq;
  logic             irq_ack;
  logic             tick_out;
  logic             running;

  int n_checks;
  int n_fail;

  timer_controller #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .wr       (wr),
    .addr     (addr),
    .wr_data  (wr_data),
    .rd_data  (rd_data),
    .irq      (irq),
    .irq_ack  (irq_ack),
    .tick_out (tick_out),
    .running  (running)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to 1 time unit after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One-cycle register write; returns in the cycle after the write
  task automatic reg_write(input logic [1:0] a, input int d);
    addr    = a;
    wr_data = d[WIDTH-1:0];
    wr      = 1'b1;
    step();
    wr      = 1'b0;
    wr_data = '0;
  endtask

  task automatic test_reset();
    logic [1:0] a;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    n_checks++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %0b expected 0", irq); end
    n_checks++;
    if (tick_out !== 1'b0) begin n_fail++; $display("FAIL reset_tick: got %0b expected 0", tick_out); end
    n_checks++;
    if (running !== 1'b0) begin n_fail++; $display("FAIL reset_running: got %0b expected 0", running); end
    for (int i = 0; i < 4; i++) begin
      a = 2'(i);
      addr = a;
      step();
      n_checks++;
      if (rd_data !== 16'h0000) begin
        n_fail++;
        $display("FAIL reset_read addr %0d: got %0h expected 0", i, rd_data);
      end
    end
  endtask

  task automatic test_oneshot_min();
    reg_write(2'd1, 0);
    reg_write(2'd2, 0);
    reg_write(2'd0, 1);  // START, one-shot; now in cycle t+1
    n_checks++;
    if (running !== 1'b1) begin n_fail++; $display("FAIL min_running_t1: got %0b expected 1", running); end
    n_checks++;
    if (tick_out !== 1'b0) begin n_fail++; $display("FAIL min_tick_t1: got %0b expected 0", tick_out); end
    step();  // t+2
    n_checks++;
    if (tick_out !== 1'b1) begin n_fail++; $display("FAIL min_tick_t2: got %0b expected 1", tick_out); end
    n_checks++;
    if (running !== 1'b0) begin n_fail++; $display("FAIL min_running_t2: got %0b expected 0", running); end
    n_checks++;
    if (irq !== 1'b1) begin n_fail++; $display("FAIL min_irq_t2: got %0b expected 1", irq); end
    step();  // t+3
    n_checks++;
    if (tick_out !== 1'b0) begin n_fail++; $display("FAIL min_tick_t3: got %0b expected 0", tick_out); end
    n_checks++;
    if (irq !== 1'b1) begin n_fail++; $display("FAIL min_irq_sticky: got %0b expected 1", irq); end
    irq_ack = 1'b1;
    step();
    irq_ack = 1'b0;
    n_checks++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL min_irq_ack: got %0b expected 0", irq); end
  endtask

  task automatic test_start_stop();
    reg_write(2'd0, 4);
    reg_write(2'd0, 5);  // START and STOP together
    n_checks++;
    if (running !== 1'b0) begin n_fail++; $display("FAIL startstop_running: got %0b expected 0", running); end
    step();
    step();
    n_checks++;
    if (running !== 1'b0) begin n_fail++; $display("FAIL startstop_later: got %0b expected 0", running); end
  endtask

  task automatic test_ack_coincide();
    irq_ack = 1'b1;
    step();
    irq_ack = 1'b0;
    reg_write(2'd1, 0);
    reg_write(2'd2, 2);
    reg_write(2'd0, 1);  // t+1
    step();              // t+2
    step();              // t+3: expiry edge ends this cycle
    irq_ack = 1'b1;
    step();              // t+4
    irq_ack = 1'b0;
    n_checks++;
    if (irq !== 1'b1) begin n_fail++; $display("FAIL ack_coincide_irq: got %0b expected 1", irq); end
    n_checks++;
    if (tick_out !== 1'b1) begin n_fail++; $display("FAIL ack_coincide_tick: got %0b expected 1", tick_out); end
  endtask

  task automatic test_rst_before_expiry();
    reg_write(2'd0, 4);
    reg_write(2'd1, 0);
    reg_write(2'd2, 2);
    reg_write(2'd0, 1);  // t+1
    addr = 2'd3;
    step();              // t+2
    step();              // t+3
    rst = 1'b1;
    step();              // t+4
    rst = 1'b0;
    n_checks++;
    if (tick_out !== 1'b0) begin n_fail++; $display("FAIL rst_tick: got %0b expected 0", tick_out); end
    n_checks++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL rst_irq: got %0b expected 0", irq); end
    n_checks++;
    if (running !== 1'b0) begin n_fail++; $display("FAIL rst_running: got %0b expected 0", running); end
    n_checks++;
    if (rd_data !== 16'h0000) begin n_fail++; $display("FAIL rst_rd: got %0h expected 0", rd_data); end
    step();
    n_checks++;
    if (tick_out !== 1'b0) begin n_fail++; $display("FAIL rst_tick_late: got %0b expected 0", tick_out); end
    n_checks++;
    if (rd_data !== 16'h0000) begin n_fail++; $display("FAIL rst_count: got %0h expected 0", rd_data); end
  endtask

  // Start the timer and compare tick_out, running and COUNT reads against the
  // enabled-cycle model. mode: 0 en always high, 1 en low for cycles 20..26,
  // 2 random en. Cycle indices are relative to the START write cycle.
  task automatic run_check(input int p, input int r, input int ncyc, input int mode,
                           input bit periodic, input bit cfg,
                           output int first_tick, output int last_tick, output int ntick);
    int  e;
    int  n;
    int  cnt_now;
    int  cnt_prev;
    bit  exp_tick;
    bit  done;
    bit  en_v;
    n = (r + 1) * (p + 1);
    if (cfg) begin
      reg_write(2'd0, 4);
      reg_write(2'd1, p);
      reg_write(2'd2, r);
    end
    reg_write(2'd0, periodic ? 3 : 1);
    addr = 2'd3;
    e = 0; exp_tick = 1'b0; done = 1'b0; cnt_prev = -1;
    first_tick = -1; last_tick = -1; ntick = 0;
    for (int i = 1; i <= ncyc; i++) begin
      if (mode == 0)      en_v = 1'b1;
      else if (mode == 1) en_v = !(i >= 20 && i < 27);
      else                en_v = ($urandom_range(3) != 0);
      en = en_v;
      n_checks++;
      if (tick_out !== exp_tick) begin
        n_fail++;
        $display("FAIL run_tick cyc %0d p=%0d r=%0d: got %0b expected %0b", i, p, r, tick_out, exp_tick);
      end
      n_checks++;
      if (running !== !done) begin
        n_fail++;
        $display("FAIL run_running cyc %0d: got %0b expected %0b", i, running, !done);
      end
      if (cnt_prev >= 0) begin
        n_checks++;
        if (rd_data !== cnt_prev[WIDTH-1:0]) begin
          n_fail++;
          $display("FAIL run_count cyc %0d p=%0d r=%0d: got %0d expected %0d", i, p, r, rd_data, cnt_prev);
        end
      end
      if (tick_out === 1'b1) begin
        if (first_tick < 0) first_tick = i;
        last_tick = i;
        ntick++;
      end
      if (done) cnt_now = 0;
      else      cnt_now = r - ((e / (p + 1)) % (r + 1));
      exp_tick = 1'b0;
      if (!done && en_v) begin
        e++;
        if (e % n == 0) begin
          exp_tick = 1'b1;
          if (!periodic) done = 1'b1;
        end
      end
      cnt_prev = cnt_now;
      step();
    end
    en = 1'b1;
  endtask

  task automatic test_periodic();
    int f, l, k;
    run_check(4, 9, 260, 0, 1'b1, 1'b1, f, l, k);
    n_checks++;
    if (f !== 51) begin n_fail++; $display("FAIL periodic_first: got %0d expected 51", f); end
    n_checks++;
    if (k !== 5) begin n_fail++; $display("FAIL periodic_count: got %0d expected 5", k); end
    n_checks++;
    if (l - f !== 200) begin n_fail++; $display("FAIL periodic_span: got %0d expected 200", l - f); end
  endtask

  task automatic test_en_gap();
    int f, l, k;
    run_check(4, 9, 260, 1, 1'b1, 1'b1, f, l, k);
    n_checks++;
    if (f !== 58) begin n_fail++; $display("FAIL engap_first: got %0d expected 58", f); end
    n_checks++;
    if (k !== 5) begin n_fail++; $display("FAIL engap_count: got %0d expected 5", k); end
    n_checks++;
    if (l - f !== 200) begin n_fail++; $display("FAIL engap_span: got %0d expected 200", l - f); end
  endtask

  task automatic test_restart();
    int f, l, k;
    reg_write(2'd0, 4);
    reg_write(2'd1, 1);
    reg_write(2'd2, 5);
    reg_write(2'd0, 1);  // t+1, count 5
    addr = 2'd3;
    for (int i = 0; i < 5; i++) step();  // t+6, count 3 in this cycle
    n_checks++;
    if (rd_data !== 16'd3) begin n_fail++; $display("FAIL restart_pre_count: got %0d expected 3", rd_data); end
    run_check(1, 5, 20, 0, 1'b0, 1'b0, f, l, k);
    n_checks++;
    if (f !== 13) begin n_fail++; $display("FAIL restart_first: got %0d expected 13", f); end
    n_checks++;
    if (k !== 1) begin n_fail++; $display("FAIL restart_count: got %0d expected 1", k); end
  endtask

  task automatic test_random();
    int f, l, k, p, r;
    bit per;
    for (int j = 0; j < 6; j++) begin
      p   = $urandom_range(3);
      r   = $urandom_range(5);
      per = 1'($urandom_range(1));
      run_check(p, r, 120, 2, per, 1'b1, f, l, k);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    en       = 1'b1;
    wr       = 1'b0;
    addr     = 2'd0;
    wr_data  = '0;
    irq_ack  = 1'b0;
    test_reset();
    test_oneshot_min();
    test_start_stop();
    test_ack_coincide();
    test_rst_before_expiry();
    test_periodic();
    test_en_gap();
    test_restart();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
